// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider: state encoding,
// default width and the conditional two's-complement negate.
package div_pkg;

  localparam int DIV_WIDTH     = 32;
  // Widest operand the negate helper handles; callers size-cast in and out.
  localparam int DIV_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Returns -v when neg is set, otherwise v. Used both for taking operand
  // magnitudes and for restoring result signs; the caller truncates.
  function automatic logic [DIV_MAX_WIDTH-1:0] neg_if(
    input logic [DIV_MAX_WIDTH-1:0] v,
    input logic                     neg
  );
    return neg ? ({DIV_MAX_WIDTH{1'b0}} - v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  assign shifted = {rem_i, dvd_msb_i};
  // Compare on W+1 bits so a remainder with its top bit set never truncates.
  assign fits    = (shifted >= {1'b0, divisor_i});
  // When it fits the true difference is below the divisor, so W bits suffice.
  assign diff    = shifted[WIDTH-1:0] - divisor_i;

  assign rem_o   = fits ? diff : shifted[WIDTH-1:0];
  assign q_bit_o = fits;

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit: quotient to lo, remainder to hi, one quotient bit
// per clock, start/busy/done handshake. WIDTH may range from 2 to 64.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Handshake: start is taken only in IDLE or DONE; while busy it is ignored.
  // done is a one-cycle pulse and lo/hi/div0 are valid from that cycle until
  // the next accepted operation overwrites them.
  div_state_e       state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] quot_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_q_q;
  logic             sign_r_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic             busy_q;
  logic             done_q;
  logic             div0_q;

  logic [WIDTH-1:0] a_mag_d;
  logic [WIDTH-1:0] b_mag_d;
  logic [WIDTH-1:0] lo_fix_d;
  logic [WIDTH-1:0] hi_fix_d;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  // Magnitudes are only taken for signed operations; DIVU uses raw operands.
  assign a_mag_d  = WIDTH'(neg_if(DIV_MAX_WIDTH'(a), signed_op & a[WIDTH-1]));
  assign b_mag_d  = WIDTH'(neg_if(DIV_MAX_WIDTH'(b), signed_op & b[WIDTH-1]));
  assign lo_fix_d = WIDTH'(neg_if(DIV_MAX_WIDTH'(quot_q), sign_q_q));
  assign hi_fix_d = WIDTH'(neg_if(DIV_MAX_WIDTH'(rem_q), sign_r_q));

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      quot_q   <= '0;
      cnt_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            sign_q_q <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r_q <= signed_op & a[WIDTH-1];
            dvd_q    <= a_mag_d;
            dsr_q    <= b_mag_d;
            rem_q    <= '0;
            quot_q   <= '0;
            cnt_q    <= '0;
            if (b == '0) begin
              // Divide by zero skips iteration and reports the raw dividend.
              state_q <= DONE;
              lo_q    <= '1;
              hi_q    <= a;
              div0_q  <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          rem_q  <= step_rem;
          dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
          quot_q <= {quot_q[WIDTH-2:0], step_q};
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        FIX: begin
          // Remainder follows the dividend's sign; overflow needs no special case.
          lo_q    <= lo_fix_d;
          hi_q    <= hi_fix_d;
          div0_q  <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign lo   = lo_q;
  assign hi   = hi_q;
  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: table of operand/result vectors plus
// hand-written sequences for ignored start, mid-run reset and back-to-back.
module tb_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         signed_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic         busy;
  logic         done;
  logic         div0;

  int total;
  int bad;

  logic [2*W-1:0] exp_q[$];

  typedef struct {
    string        name;
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         z;
  } vec_t;

  vec_t vecs[$];

  div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .lo        (lo),
    .hi        (hi),
    .busy      (busy),
    .done      (done),
    .div0      (div0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic add_vec(input string name, input logic s, input logic [W-1:0] va,
                         input logic [W-1:0] vb, input logic [W-1:0] vlo,
                         input logic [W-1:0] vhi, input logic vz);
    vec_t v;
    v.name = name; v.s = s; v.a = va; v.b = vb; v.lo = vlo; v.hi = vhi; v.z = vz;
    vecs.push_back(v);
  endtask

  // Drive an operation at the current negedge; it is accepted at the next posedge.
  task automatic issue(input logic s, input logic [W-1:0] va, input logic [W-1:0] vb);
    start     = 1'b1;
    signed_op = s;
    a         = va;
    b         = vb;
  endtask

  // Counts cycles from the accept edge to done, checking busy on every cycle.
  // glitch > 0 raises a stray start in that cycle. cyc = -1 means timeout.
  task automatic wait_done(input bit z, input int glitch, output int cyc, output int busy_err);
    busy_err = 0;
    cyc      = -1;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == glitch) begin
        start = 1'b1; signed_op = 1'b0; a = 32'd9; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (busy !== (!z && k <= W + 1)) busy_err++;
      if (done === 1'b1) begin
        cyc = k;
        return;
      end
    end
  endtask

  task automatic check_result(input string name, input bit z, input int cyc, input int busy_err);
    logic [2*W-1:0] e;
    e = exp_q.pop_front();
    check({name, " done_cycle"}, W'(cyc), z ? W'(1) : W'(W + 2));
    check({name, " busy_window"}, W'(busy_err), W'(0));
    check({name, " lo"}, lo, e[2*W-1:W]);
    check({name, " hi"}, hi, e[W-1:0]);
    check({name, " div0"}, W'(div0), W'(z));
  endtask

  initial begin
    int cyc;
    int berr;
    int done_seen;
    total = 0;
    bad   = 0;
    rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;

    add_vec("u100_7",     1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0);
    add_vec("s_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    add_vec("s_7_m2",     1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0);
    add_vec("u_ff_2",     1'b0, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 32'd1,        1'b0);
    add_vec("s_ff_2",     1'b1, 32'hFFFFFFFF, 32'd2,        32'd0,        32'hFFFFFFFF, 1'b0);
    add_vec("u5_0",       1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1);
    add_vec("u9_3",       1'b0, 32'd9,        32'd3,        32'd3,        32'd0,        1'b0);
    add_vec("s_ovf",      1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0);
    add_vec("u_min_ff",   1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0);
    add_vec("s_m5_0",     1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
    add_vec("s_m100_m7",  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0);
    add_vec("u0_5",       1'b0, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0);
    add_vec("u_ff_ff",    1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0);
    add_vec("u_fe_ff",    1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFE, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst lo", lo, '0);
    check("rst hi", hi, '0);
    check("rst busy", W'(busy), '0);
    check("rst done", W'(done), '0);
    check("rst div0", W'(div0), '0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].lo, vecs[i].hi});
      issue(vecs[i].s, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].z, 0, cyc, berr);
      check_result(vecs[i].name, vecs[i].z, cyc, berr);
      @(negedge clk);
    end

    // stray start in cycle 10 must not disturb the running 100/7
    exp_q.push_back({32'd14, 32'd2});
    issue(1'b0, 32'd100, 32'd7);
    wait_done(1'b0, 10, cyc, berr);
    check_result("glitch", 1'b0, cyc, berr);
    @(negedge clk);

    // reset asserted in cycle 20 of a run
    issue(1'b1, 32'd1000, 32'd10);
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 20) rst_n = 1'b0;
    end
    @(negedge clk);
    check("midrst busy", W'(busy), '0);
    check("midrst lo", lo, '0);
    check("midrst hi", hi, '0);
    check("midrst done", W'(done), '0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check("midrst no_done", W'(done_seen), '0);

    // back-to-back: second start raised in the DONE cycle of the first
    exp_q.push_back({32'd14, 32'd2});
    issue(1'b0, 32'd100, 32'd7);
    wait_done(1'b0, 0, cyc, berr);
    check_result("b2b_first", 1'b0, cyc, berr);
    exp_q.push_back({32'hFFFFFFFD, 32'hFFFFFFFF});
    issue(1'b1, 32'hFFFFFFF9, 32'd2);
    wait_done(1'b0, 0, cyc, berr);
    check_result("b2b_second", 1'b0, cyc, berr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
